ro_freq_monitor: RTL and testbench

//  Parametrised successor to the single-RO enable block: N_CH ring-oscillator enables plus an

---
 rtl/ro_freq_monitor.sv | 234 +++++++++++++++++++++++
 tb/tb_ro_freq_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_monitor.sv
// -----------------------------------------------------------------------------
// ro_freq_monitor
//
// Purpose:
//   Drives N_CH ring-oscillator enables and measures each oscillator by
//   counting rising edges of its (pre-divided) output over a programmable
//   gate window. Software programs RO_EN and GATE, then writes START; the
//   per-channel counts are read back through the CL register interface.
//
//   Register map (offsets from BASE_ADDR):
//     +0x00      RO_EN    RW  [N_CH-1:0]
//     +0x04      GATE     RW  [31:0]
//     +0x08      CMD      W   bit0 = START
//                         R   {30'b0, done, busy}
//     +0x18+4*i  COUNT[i] RO  zero-extended to 32 bits
//   Any other read address (including COUNT[i] with i >= N_CH) returns
//   32'hdeaddead.
//
// Ports:
//   clk_main_a0    in   main clock, all logic on posedge
//   rst_main_sync  in   synchronous active-high reset
//   wr_addr        in   write address, qualified by wready
//   wready         in   single-cycle write strobe
//   wdata          in   write data
//   arvalid_q      in   single-cycle read request
//   araddr_q       in   read address, qualified by arvalid_q
//   rready         in   read-data accept
//   rvalid         out  read data valid
//   rdata          out  read data
//   rresp          out  read response, always OKAY (2'b00)
//   ro_en          out  per-channel RO enable (registered)
//   ro_in          in   RO outputs, asynchronous to clk_main_a0
//   busy           out  measurement in progress
//   done           out  sticky measurement-complete flag
// -----------------------------------------------------------------------------
module ro_freq_monitor #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0508
) (
    input  logic            clk_main_a0,
    input  logic            rst_main_sync,
    input  logic [31:0]     wr_addr,
    input  logic            wready,
    input  logic [31:0]     wdata,
    input  logic            arvalid_q,
    input  logic [31:0]     araddr_q,
    input  logic            rready,
    output logic            rvalid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic [N_CH-1:0] ro_en,
    input  logic [N_CH-1:0] ro_in,
    output logic            busy,
    output logic            done
);

    localparam logic [31:0] OFS_RO_EN = 32'h00;
    localparam logic [31:0] OFS_GATE  = 32'h04;
    localparam logic [31:0] OFS_CMD   = 32'h08;
    localparam logic [31:0] OFS_COUNT = 32'h18;
    localparam logic [31:0] RD_UNMAP  = 32'hdead_dead;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_DONE
    } state_t;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[CNT_W-1:0] = v;
        return r;
    endfunction

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         gate_q;
    logic [31:0]         gate_cnt_q;
    logic [N_CH-1:0]     ro_en_q;
    logic [CNT_W-1:0]    cnt_q [N_CH];
    logic [N_CH-1:0]     sync_q [SYNC_STAGES];
    logic [N_CH-1:0]     prev_q;
    logic                rvalid_q;
    logic [31:0]         rdata_q;

    logic [31:0]         wr_ofs;
    logic [31:0]         rd_ofs;
    logic                wr_ro_en;
    logic                wr_gate;
    logic                start_req;
    logic [N_CH-1:0]     edge_d;
    logic [31:0]         rdata_d;

    // Address decode relative to BASE_ADDR; exact 32-bit match only.
    assign wr_ofs    = wr_addr - BASE_ADDR;
    assign rd_ofs    = araddr_q - BASE_ADDR;
    assign wr_ro_en  = wready && (wr_ofs == OFS_RO_EN);
    assign wr_gate   = wready && (wr_ofs == OFS_GATE);
    assign start_req = wready && (wr_ofs == OFS_CMD) && wdata[0];

    // ---- Input synchroniser and rising-edge detector ----
    // Pure data path, so no reset: the chain flushes within SYNC_STAGES+1
    // cycles and counting is only enabled after ARM anyway.
    always_ff @(posedge clk_main_a0) begin
        sync_q[0] <= ro_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
        end
        prev_q <= sync_q[SYNC_STAGES-1];
    end

    // An edge only counts while its channel is currently enabled, so
    // clearing RO_EN mid-run freezes that channel's count.
    assign edge_d = sync_q[SYNC_STAGES-1] & ~prev_q & ro_en_q;

    // ---- Configuration registers ----
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            ro_en_q <= '0;
            gate_q  <= '0;
        end else begin
            if (wr_ro_en) begin
                ro_en_q <= wdata[N_CH-1:0];
            end
            if (wr_gate) begin
                gate_q <= wdata;
            end
        end
    end

    // ---- Measurement FSM with registered busy/done and counters ----
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gate_cnt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    // START is only honoured here, so a START during a run is dropped.
                    if (start_req) begin
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    for (int i = 0; i < N_CH; i++) begin
                        cnt_q[i] <= '0;
                    end
                    gate_cnt_q <= gate_q;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= (gate_q == 32'd0) ? S_DONE : S_COUNT;
                end
                S_COUNT: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (edge_d[i]) begin
                            cnt_q[i] <= sat_inc(cnt_q[i]);
                        end
                    end
                    gate_cnt_q <= gate_cnt_q - 32'd1;
                    // Leaving on gate_cnt==1 gives exactly GATE counting cycles.
                    if (gate_cnt_q == 32'd1) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ---- Read data mux (live values) ----
    always_comb begin
        rdata_d = RD_UNMAP;
        if (rd_ofs == OFS_RO_EN) begin
            rdata_d = '0;
            rdata_d[N_CH-1:0] = ro_en_q;
        end else if (rd_ofs == OFS_GATE) begin
            rdata_d = gate_q;
        end else if (rd_ofs == OFS_CMD) begin
            rdata_d = {30'b0, done_q, busy_q};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (rd_ofs == OFS_COUNT + 32'(4 * i)) begin
                    rdata_d = zext_cnt(cnt_q[i]);
                end
            end
        end
    end

    // ---- Read response channel ----
    // A request arriving while data is still pending is dropped so the
    // pending rdata is never overwritten.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (arvalid_q && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
        end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = 2'b00;
    assign ro_en  = ro_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ro_freq_monitor.sv
module tb_ro_freq_monitor;

    localparam logic [31:0] BASE = 32'h0000_0508;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_addr;
    logic        wready;
    logic [31:0] wdata;
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
    logic [3:0]  ro_in;

    logic        rvalid_w, rvalid_n;
    logic [31:0] rdata_w, rdata_n;
    logic [1:0]  rresp_w, rresp_n;
    logic [3:0]  ro_en_w, ro_en_n;
    logic        busy_w, busy_n, done_w, done_n;

    always #5 clk = ~clk;

    // Full-width instance and an 8-bit counter instance share the same bus.
    ro_freq_monitor #(.N_CH(4), .CNT_W(32), .SYNC_STAGES(2), .BASE_ADDR(BASE)) dut_w (
        .clk_main_a0(clk), .rst_main_sync(rst),
        .wr_addr(wr_addr), .wready(wready), .wdata(wdata),
        .arvalid_q(arvalid), .araddr_q(araddr), .rready(rready),
        .rvalid(rvalid_w), .rdata(rdata_w), .rresp(rresp_w),
        .ro_en(ro_en_w), .ro_in(ro_in), .busy(busy_w), .done(done_w)
    );

    ro_freq_monitor #(.N_CH(4), .CNT_W(8), .SYNC_STAGES(2), .BASE_ADDR(BASE)) dut_n (
        .clk_main_a0(clk), .rst_main_sync(rst),
        .wr_addr(wr_addr), .wready(wready), .wdata(wdata),
        .arvalid_q(arvalid), .araddr_q(araddr), .rready(rready),
        .rvalid(rvalid_n), .rdata(rdata_n), .rresp(rresp_n),
        .ro_en(ro_en_n), .ro_in(ro_in), .busy(busy_n), .done(done_n)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tog_half = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        bit          narrow;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb[$];

    // RO stimulus: ro_in[1:0] toggle together every tog_half cycles.
    initial begin
        int tc;
        tc = 0;
        ro_in = 4'b0000;
        forever begin
            @(negedge clk);
            if (tog_half == 0) begin
                tc = 0;
            end else begin
                tc++;
                if (tc >= tog_half) begin
                    tc = 0;
                    ro_in[1:0] = ~ro_in[1:0];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        assert ((lo == hi) ? (obs === lo) : (obs >= lo && obs <= hi))
        else begin
            errors++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d..%0d", tag, obs, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
        wr_addr = BASE + ofs;
        wdata   = data;
        wready  = 1'b1;
        tick();
        wready  = 1'b0;
    endtask

    // Scoreboarded read: expectation queued when the request is driven,
    // popped and compared when rvalid appears.
    task automatic rd(input string tag, input logic [31:0] ofs, input bit narrow,
                      input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        bit   got;
        e.tag = tag; e.narrow = narrow; e.lo = lo; e.hi = hi;
        sb.push_back(e);
        araddr  = BASE + ofs;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (rvalid_w && rvalid_n) got = 1'b1;
            else tick();
        end
        e = sb.pop_front();
        if (!got) begin
            chk({e.tag, "_rvalid"}, {31'b0, rvalid_w}, 32'd1, 32'd1);
        end else begin
            chk(e.tag, e.narrow ? rdata_n : rdata_w, e.lo, e.hi);
            tick();
        end
    endtask

    task automatic wait_done(input int s, input int budget, output int dt);
        tick();
        while (!done_w && (cyc - s) < budget) tick();
        dt = cyc - s;
    endtask

    int s;
    int dt;

    initial begin
        rst = 1'b1; wready = 1'b0; wr_addr = '0; wdata = '0;
        arvalid = 1'b0; araddr = '0; rready = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();

        // 1) Reset state and unmapped reads
        chk("rst_rvalid", {31'b0, rvalid_w}, 0, 0);
        chk("rst_rdata",  rdata_w, 0, 0);
        chk("rst_rresp",  {30'b0, rresp_w}, 0, 0);
        chk("rst_busy_done", {30'b0, busy_w, done_w}, 0, 0);
        chk("rst_ro_en",  {28'b0, ro_en_w}, 0, 0);
        rd("rst_cmd",    32'h08, 0, 0, 0);
        rd("rst_count0", 32'h18, 0, 0, 0);
        rd("rst_gate",   32'h04, 0, 0, 0);
        rd("unmapped40", 32'h40, 0, 32'hdeaddead, 32'hdeaddead);
        rd("count4_oob", 32'h28, 0, 32'hdeaddead, 32'hdeaddead);

        // 2) Basic measurement, clk/8 on ro_in[1:0], only channel 0 enabled
        wr(32'h00, 32'h1);
        chk("ro_en_next", {28'b0, ro_en_w}, 1, 1);
        rd("ro_en_rb", 32'h00, 0, 1, 1);
        wr(32'h04, 32'd100);
        rd("gate_rb", 32'h04, 0, 100, 100);
        tog_half = 4;
        repeat (10) tick();
        wr(32'h08, 32'h1);
        s = cyc;
        tick();
        chk("t2_busy", {31'b0, busy_w}, 1, 1);
        wait_done(s, 500, dt);
        chk("t2_latency", dt, 102, 102);
        chk("t2_flags", {30'b0, done_w, busy_w}, 2, 2);
        rd("t2_count0",   32'h18, 0, 12, 13);
        rd("t2_count0_n", 32'h18, 1, 12, 13);
        rd("t2_count1",   32'h1c, 0, 0, 0);
        rd("t2_count2",   32'h20, 0, 0, 0);
        rd("t2_count3",   32'h24, 0, 0, 0);
        rd("t2_cmd",      32'h08, 0, 2, 2);

        // 3) GATE=0: straight to done, counts cleared
        wr(32'h04, 32'd0);
        wr(32'h08, 32'h1);
        s = cyc;
        wait_done(s, 20, dt);
        chk("t3_latency", dt, 1, 3);
        rd("t3_count0", 32'h18, 0, 0, 0);
        rd("t3_cmd",    32'h08, 0, 2, 2);

        // 4) Saturation: clk/4 for 2000 cycles -> 500 edges
        tog_half = 2;
        wr(32'h04, 32'd2000);
        wr(32'h08, 32'h1);
        s = cyc;
        wait_done(s, 3000, dt);
        chk("t4_latency", dt, 2002, 2002);
        rd("t4_count0_sat", 32'h18, 1, 255, 255);
        rd("t4_count0_w",   32'h18, 0, 499, 501);

        // 5) START ignored mid-run, GATE write deferred, RO_EN cleared mid-run
        tog_half = 4;
        wr(32'h04, 32'd1000);
        wr(32'h08, 32'h1);
        s = cyc;
        wait_until(s + 100);
        wr(32'h08, 32'h1);
        wait_until(s + 150);
        wr(32'h04, 32'd5);
        rd("t5_cmd_busy", 32'h08, 0, 1, 1);
        wait_until(s + 300);
        rd("t5_live_count", 32'h18, 0, 36, 39);
        wait_until(s + 400);
        wr(32'h00, 32'h0);
        chk("t5_ro_en_clr", {28'b0, ro_en_w}, 0, 0);
        wait_done(s, 2000, dt);
        chk("t5_latency", dt, 1002, 1002);
        rd("t5_count0",   32'h18, 0, 49, 51);
        rd("t5_count0_n", 32'h18, 1, 49, 51);
        wr(32'h08, 32'h1);
        s = cyc;
        wait_done(s, 50, dt);
        chk("t5_next_gate", dt, 7, 7);

        // 6) Read back-pressure, then reset during COUNT
        wr(32'h04, 32'd77);
        rready  = 1'b0;
        araddr  = BASE + 32'h04;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("t6_rvalid1", {31'b0, rvalid_w}, 1, 1);
        chk("t6_rdata1",  rdata_w, 77, 77);
        tick();
        tick();
        araddr  = BASE + 32'h08;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("t6_rdata_held", rdata_w, 77, 77);
        tick();
        chk("t6_rvalid_held", {31'b0, rvalid_w}, 1, 1);
        chk("t6_rdata_held2", rdata_w, 77, 77);
        rready = 1'b1;
        tick();
        chk("t6_rvalid_drop", {31'b0, rvalid_w}, 0, 0);
        chk("t6_rdata_zero",  rdata_w, 0, 0);

        wr(32'h00, 32'h1);
        wr(32'h04, 32'd1000);
        wr(32'h08, 32'h1);
        repeat (200) tick();
        rd("t6_pre_rst_count", 32'h18, 0, 20, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_flags", {30'b0, busy_w, done_w}, 0, 0);
        chk("t6_rst_ro_en", {28'b0, ro_en_w}, 0, 0);
        rd("t6_rst_count0", 32'h18, 0, 0, 0);
        rd("t6_rst_gate",   32'h04, 0, 0, 0);
        repeat (20) tick();
        rd("t6_rst_cmd",    32'h08, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
